mem_req_scheduler: RTL and testbench
====================================

# mem_req_scheduler

Two-client memory request scheduler between the private LXa/LXb caches and the single downstream memory port. It replaces the one-deep "both requested" overflow buffer with per-client request FIFOs, round-robin grant, a ready/valid handshake on both sides and an in-order read-tag queue that routes returning cachelines to the issuing client. Upstream back-pressure is explicit (`req_ready_*`), so simultaneous or bursty requests are never lost.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `LINE_W`, 128, cacheline width
- `REQ_DEPTH`, 2, per-client request FIFO depth (power of two, ≥2)
- `MAX_RD`, 4, maximum outstanding reads (power of two, ≥2)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `req_valid_a` / `req_valid_b`  in  1  request present
- `req_ready_a` / `req_ready_b`  out  1  request accepted when valid&ready
- `req_wr_a` / `req_wr_b`  in  1  1 = write, 0 = read
- `req_addr_a` / `req_addr_b`  in  ADDR_W  line address
- `req_data_a` / `req_data_b`  in  LINE_W  write cacheline, ignored for reads
- `rsp_valid_a` / `rsp_valid_b`  out  1  read cacheline valid for this client
- `rsp_data_a` / `rsp_data_b`  out  LINE_W  read cacheline
- `mem_valid`  out  1  downstream request valid
- `mem_ready`  in  1  downstream accepts when valid&ready
- `mem_wr`  out  1  downstream write/read
- `mem_addr`  out  ADDR_W  downstream address
- `mem_data`  out  LINE_W  downstream write data
- `mem_client`  out  1  issuing client, 0 = A, 1 = B
- `mem_rsp_valid`  in  1  read data returning (in issue order)
- `mem_rsp_data`  in  LINE_W  returning cacheline
- `rsp_orphan_err`  out  1  sticky: response arrived with no read outstanding

## Operation
- Accept: `req_ready_x = reset_n & !fifo_x_full`. Handshake pushes {wr, addr, data} into FIFO x. `req_ready_x` does not depend on `req_valid_x`.
- Eligibility: FIFO x head eligible if non-empty and (head is write, or read-tag queue not full).
- Grant: only when output stage can load (`!mem_valid | mem_ready`). One eligible → it wins. Both eligible → the client not in `last_grant` wins. `last_grant` updates on every grant.
- Output stage: registered; on grant loads head fields plus `mem_client`, pops the winning FIFO, sets `mem_valid`. Fields are held stable while `mem_valid & !mem_ready`. If `mem_ready` arrives with no new grant, `mem_valid` clears.
- Read tags: when a read is granted, its client ID is pushed into the tag queue (depth MAX_RD). On `mem_rsp_valid` the queue pops. `rsp_valid_<popped>` = 1 and both `rsp_data_*` = `mem_rsp_data` in the same cycle (combinational).
- If pop and push happen in the same cycle, both take effect, including when the queue is full.
- Writes produce no response.
- `mem_rsp_valid` with an empty tag queue: both `rsp_valid_*` = 0, response dropped, `rsp_orphan_err` set until reset.

## Timing
- Reset values (reset_n = 0 at an edge): all FIFOs and the tag queue empty, `mem_valid` = 0, `mem_wr`/`mem_addr`/`mem_data`/`mem_client` = 0, `last_grant` = B (A wins the first tie), `rsp_orphan_err` = 0. `req_ready_*` = 0 while reset_n = 0. `rsp_valid_*` = 0 while the tag queue is empty.
- Reset mid-operation: all queued and outstanding requests are discarded. Any `mem_rsp_valid` after reset sets `rsp_orphan_err`.
- Latency: request accepted in cycle N → `mem_valid` high in N+2 at the earliest (FIFO write at N, grant in N+1).
- Throughput: one downstream request per cycle while `mem_ready` = 1 and FIFOs are non-empty. Under a tie with `mem_ready` held high, grants alternate A,B,A,B.
- FIFO full, with pop and push in the same cycle: `req_ready_x` still shows full (0) that cycle. No combinational ready-through.
- Response routing: zero-cycle latency from `mem_rsp_valid`.

## Structure
- Package `mem_sched_pkg`:
  - `client_e` (`CLIENT_A` = 0, `CLIENT_B` = 1)
  - request struct {wr, addr, data}
  - default width constants
- Sub-module `sync_fifo` (parameterised width/depth, full/empty, simultaneous push/pop). Instantiated three times: FIFO A, FIFO B, and the 1-bit tag queue.
- Top level holds the grant logic, the output register and the error flag.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with `req_valid_a` = 1 → `req_ready_*` = 0, `mem_valid` = 0. Release → `req_ready_a` = 1 next cycle.
- Single read: A reads 0x0000_1000, `mem_ready` = 1 → `mem_valid` two cycles later with `mem_client` = 0. Then `mem_rsp_valid` with data 0xDEAD…BEEF → `rsp_valid_a` = 1, `rsp_valid_b` = 0 same cycle.
- Tie/fairness: A and B each push 2 writes in the same cycles, `mem_ready` = 1 → downstream order A,B,A,B.
- Back-pressure: `mem_ready` = 0 for 10 cycles while A streams requests → `mem_*` stable, A FIFO fills, `req_ready_a` = 0 after 2 accepts beyond the output stage. Release → all drain in order, none lost.
- Tag limit: issue 5 reads (MAX_RD = 4), no responses → 4th read is the last issued, 5th held. One response → 5th issues. Responses route to clients in issue order.
- Orphan: `mem_rsp_valid` with no outstanding read → no `rsp_valid_*`, `rsp_orphan_err` = 1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and default widths for the two-client memory request scheduler.
package mem_sched_pkg;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_LINE_W    = 128;
  localparam int DEF_REQ_DEPTH = 2;
  localparam int DEF_MAX_RD    = 4;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LINE_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is taken only
// when a pop happens in the same cycle, so occupancy never exceeds DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Two-client memory request scheduler: per-client request FIFOs, round-robin
// grant into a registered downstream stage, and an in-order read-tag queue.
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int REQ_DEPTH = DEF_REQ_DEPTH,
  parameter int MAX_RD    = DEF_MAX_RD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_a,
  output logic              req_ready_a,
  input  logic              req_wr_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [LINE_W-1:0] req_data_a,
  input  logic              req_valid_b,
  output logic              req_ready_b,
  input  logic              req_wr_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [LINE_W-1:0] req_data_b,
  output logic              rsp_valid_a,
  output logic [LINE_W-1:0] rsp_data_a,
  output logic              rsp_valid_b,
  output logic [LINE_W-1:0] rsp_data_b,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data,
  output logic              mem_client,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              rsp_orphan_err
);

  localparam int REQ_W = 1 + ADDR_W + LINE_W;

  logic [REQ_W-1:0]  head_a, head_b;
  logic              full_a, empty_a, full_b, empty_b;
  logic              tag_full, tag_empty, tag_head;
  logic              head_wr_a, head_wr_b;
  logic [ADDR_W-1:0] head_addr_a, head_addr_b;
  logic [LINE_W-1:0] head_data_a, head_data_b;
  logic              can_load, elig_a, elig_b, grant_a, grant_b, tag_push;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  client_e           mem_client_q, mem_client_d;
  client_e           last_grant_q, last_grant_d;
  logic              orphan_q, orphan_d;

  assign req_ready_a = reset_n & ~full_a;
  assign req_ready_b = reset_n & ~full_b;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_fifo_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid_a & req_ready_a),
    .wdata   ({req_wr_a, req_addr_a, req_data_a}),
    .pop     (grant_a),
    .rdata   (head_a),
    .full    (full_a),
    .empty   (empty_a)
  );

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_fifo_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid_b & req_ready_b),
    .wdata   ({req_wr_b, req_addr_b, req_data_b}),
    .pop     (grant_b),
    .rdata   (head_b),
    .full    (full_b),
    .empty   (empty_b)
  );

  // Each entry records which client issued an outstanding read, oldest first.
  sync_fifo #(.WIDTH(1), .DEPTH(MAX_RD)) u_tag_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tag_push),
    .wdata   (grant_b),
    .pop     (mem_rsp_valid),
    .rdata   (tag_head),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  assign {head_wr_a, head_addr_a, head_data_a} = head_a;
  assign {head_wr_b, head_addr_b, head_data_b} = head_b;

  // A read may only be granted while a tag slot is free to route its data back.
  assign can_load = ~mem_valid_q | mem_ready;
  assign elig_a   = ~empty_a & (head_wr_a | ~tag_full);
  assign elig_b   = ~empty_b & (head_wr_b | ~tag_full);
  assign grant_a  = can_load & elig_a & (~elig_b | (last_grant_q == CLIENT_B));
  assign grant_b  = can_load & elig_b & (~elig_a | (last_grant_q == CLIENT_A));
  assign tag_push = (grant_a & ~head_wr_a) | (grant_b & ~head_wr_b);

  assign rsp_valid_a = mem_rsp_valid & ~tag_empty & ~tag_head;
  assign rsp_valid_b = mem_rsp_valid & ~tag_empty & tag_head;
  assign rsp_data_a  = mem_rsp_data;
  assign rsp_data_b  = mem_rsp_data;

  always_comb begin
    mem_valid_d  = mem_valid_q & ~mem_ready;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_client_d = mem_client_q;
    last_grant_d = last_grant_q;
    orphan_d     = orphan_q | (mem_rsp_valid & tag_empty);
    if (grant_a) begin
      mem_valid_d  = 1'b1;
      mem_wr_d     = head_wr_a;
      mem_addr_d   = head_addr_a;
      mem_data_d   = head_data_a;
      mem_client_d = CLIENT_A;
      last_grant_d = CLIENT_A;
    end else if (grant_b) begin
      mem_valid_d  = 1'b1;
      mem_wr_d     = head_wr_b;
      mem_addr_d   = head_addr_b;
      mem_data_d   = head_data_b;
      mem_client_d = CLIENT_B;
      last_grant_d = CLIENT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_valid_q  <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_client_q <= CLIENT_A;
      last_grant_q <= CLIENT_B;
      orphan_q     <= 1'b0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_client_q <= mem_client_d;
      last_grant_q <= last_grant_d;
      orphan_q     <= orphan_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign mem_client     = mem_client_q;
  assign rsp_orphan_err = orphan_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Scoreboard bench for mem_req_scheduler: expected downstream requests and
// read-response routing are queued on stimulus and checked as the DUT emits them.
module tb_mem_req_scheduler;
  import mem_sched_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid_a, req_ready_a, req_wr_a;
  logic [31:0]  req_addr_a;
  logic [127:0] req_data_a;
  logic         req_valid_b, req_ready_b, req_wr_b;
  logic [31:0]  req_addr_b;
  logic [127:0] req_data_b;
  logic         rsp_valid_a, rsp_valid_b;
  logic [127:0] rsp_data_a, rsp_data_b;
  logic         mem_valid, mem_ready, mem_wr, mem_client;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         rsp_orphan_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int issued_cnt = 0;

  mem_req_t exp_a_q[$];
  mem_req_t exp_b_q[$];
  bit       tag_model_q[$];
  bit       issue_log_q[$];

  always #5 clk = ~clk;

  mem_req_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_a    (req_valid_a),
    .req_ready_a    (req_ready_a),
    .req_wr_a       (req_wr_a),
    .req_addr_a     (req_addr_a),
    .req_data_a     (req_data_a),
    .req_valid_b    (req_valid_b),
    .req_ready_b    (req_ready_b),
    .req_wr_b       (req_wr_b),
    .req_addr_b     (req_addr_b),
    .req_data_b     (req_data_b),
    .rsp_valid_a    (rsp_valid_a),
    .rsp_data_a     (rsp_data_a),
    .rsp_valid_b    (rsp_valid_b),
    .rsp_data_b     (rsp_data_b),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_client     (mem_client),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rsp_orphan_err (rsp_orphan_err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic mem_req_t mkReq(input logic wr, input logic [31:0] addr);
    mem_req_t r;
    r.wr   = wr;
    r.addr = addr;
    r.data = {addr, ~addr, addr ^ 32'hA5A5_5A5A, addr + 32'd7};
    return r;
  endfunction

  // Monitor: route-check every response and match every downstream handshake.
  always @(negedge clk) begin
    mem_req_t e;
    bit       c;
    if (reset_n !== 1'b1) begin
      tag_model_q.delete();
    end else begin
      if (mem_rsp_valid) begin
        if (tag_model_q.size() == 0) begin
          checkOutput("orphan_rsp_valid", 128'({rsp_valid_a, rsp_valid_b}), 128'd0);
        end else begin
          c = tag_model_q.pop_front();
          checkOutput("rsp_valid_a", 128'(rsp_valid_a), 128'(!c));
          checkOutput("rsp_valid_b", 128'(rsp_valid_b), 128'(c));
          checkOutput(c ? "rsp_data_b" : "rsp_data_a", c ? rsp_data_b : rsp_data_a, mem_rsp_data);
        end
      end else begin
        checkOutput("idle_rsp_valid", 128'({rsp_valid_a, rsp_valid_b}), 128'd0);
      end
      if (mem_valid && mem_ready) begin
        issued_cnt++;
        issue_log_q.push_back(mem_client);
        if ((mem_client ? exp_b_q.size() : exp_a_q.size()) == 0) begin
          checkOutput("unexpected_req", 128'(mem_client), 128'd2);
        end else begin
          e = mem_client ? exp_b_q.pop_front() : exp_a_q.pop_front();
          checkOutput("mem_wr", 128'(mem_wr), 128'(e.wr));
          checkOutput("mem_addr", 128'(mem_addr), 128'(e.addr));
          if (e.wr) checkOutput("mem_data", mem_data, e.data);
          if (!e.wr) tag_model_q.push_back(mem_client);
        end
      end
    end
  end

  // Present requests on the selected clients and hold each until accepted.
  task automatic applyStimulus(input bit en_a, input mem_req_t ra, input bit en_b, input mem_req_t rb);
    bit pend_a = en_a;
    bit pend_b = en_b;
    int cyc = 0;
    req_valid_a = en_a; req_wr_a = ra.wr; req_addr_a = ra.addr; req_data_a = ra.data;
    req_valid_b = en_b; req_wr_b = rb.wr; req_addr_b = rb.addr; req_data_b = rb.data;
    while ((pend_a || pend_b) && cyc < 200) begin
      @(negedge clk);
      if (pend_a && req_ready_a) begin exp_a_q.push_back(ra); pend_a = 0; end
      if (pend_b && req_ready_b) begin exp_b_q.push_back(rb); pend_b = 0; end
      @(posedge clk); #1;
      if (!pend_a) req_valid_a = 1'b0;
      if (!pend_b) req_valid_b = 1'b0;
      cyc++;
    end
    if (pend_a || pend_b) begin
      checkOutput("accept_timeout", 128'({pend_a, pend_b}), 128'd0);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendResponse(input logic [127:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic doReset(input int n);
    reset_n     = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    waitCycles(n);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: sim time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_req_t bp[4];
    bit       exp_order[4];
    int       idx, acc, base;
    bit       snap_ok;
    logic [31:0]  snap_addr;
    logic [127:0] snap_data;

    reset_n = 1'b0;
    req_valid_a = 1'b0; req_wr_a = 1'b0; req_addr_a = '0; req_data_a = '0;
    req_valid_b = 1'b0; req_wr_b = 1'b0; req_addr_b = '0; req_data_b = '0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(posedge clk); #1;

    // Reset held with a pending request: nothing accepted, outputs cleared.
    req_valid_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_ready_a", 128'(req_ready_a), 128'd0);
      checkOutput("rst_ready_b", 128'(req_ready_b), 128'd0);
      checkOutput("rst_mem_valid", 128'(mem_valid), 128'd0);
    end
    checkOutput("rst_mem_addr", 128'(mem_addr), 128'd0);
    checkOutput("rst_mem_client", 128'(mem_client), 128'd0);
    checkOutput("rst_orphan", 128'(rsp_orphan_err), 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    req_valid_a = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready_a", 128'(req_ready_a), 128'd1);
    @(posedge clk); #1;

    // Single read with two-cycle latency, then routed response.
    mem_ready = 1'b1;
    applyStimulus(1'b1, mkReq(1'b0, 32'h0000_1000), 1'b0, mkReq(1'b0, 32'h0));
    checkOutput("lat_n1_valid", 128'(mem_valid), 128'd0);
    waitCycles(1);
    checkOutput("lat_n2_valid", 128'(mem_valid), 128'd1);
    checkOutput("lat_n2_client", 128'(mem_client), 128'd0);
    waitCycles(1);
    sendResponse(128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF);
    waitCycles(1);

    // Tie from reset: writes from both clients alternate A,B,A,B.
    doReset(2);
    issue_log_q.delete();
    applyStimulus(1'b1, mkReq(1'b1, 32'h100), 1'b1, mkReq(1'b1, 32'h200));
    applyStimulus(1'b1, mkReq(1'b1, 32'h104), 1'b1, mkReq(1'b1, 32'h204));
    waitCycles(6);
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    checkOutput("tie_count", 128'(issue_log_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < issue_log_q.size(); i++)
      checkOutput($sformatf("tie_order_%0d", i), 128'(issue_log_q[i]), 128'(exp_order[i]));

    // Back-pressure: output stage plus two FIFO entries, then A stalls.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) bp[i] = mkReq(1'b1, 32'h300 + 32'(i * 4));
    idx = 0; acc = 0; snap_ok = 0; snap_addr = '0; snap_data = '0;
    req_valid_a = 1'b1; req_wr_a = bp[0].wr; req_addr_a = bp[0].addr; req_data_a = bp[0].data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (!snap_ok) begin
          snap_ok = 1; snap_addr = mem_addr; snap_data = mem_data;
        end else begin
          checkOutput("bp_stable_addr", 128'(mem_addr), 128'(snap_addr));
          checkOutput("bp_stable_data", mem_data, snap_data);
        end
      end
      if (req_valid_a && req_ready_a) begin exp_a_q.push_back(bp[idx]); idx++; acc++; end
      @(posedge clk); #1;
      if (idx < 4) begin
        req_wr_a = bp[idx].wr; req_addr_a = bp[idx].addr; req_data_a = bp[idx].data;
      end else req_valid_a = 1'b0;
    end
    checkOutput("bp_accepts", 128'(acc), 128'd3);
    @(negedge clk);
    checkOutput("bp_ready_a", 128'(req_ready_a), 128'd0);
    checkOutput("bp_mem_valid", 128'(mem_valid), 128'd1);
    checkOutput("bp_mem_addr", 128'(mem_addr), 128'(bp[0].addr));
    @(posedge clk); #1;
    mem_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (req_valid_a && req_ready_a) begin exp_a_q.push_back(bp[idx]); idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin
        req_wr_a = bp[idx].wr; req_addr_a = bp[idx].addr; req_data_a = bp[idx].data;
      end
    end
    req_valid_a = 1'b0;
    checkOutput("bp_all_accepted", 128'(idx), 128'd4);
    waitCycles(6);
    checkOutput("bp_drained", 128'(exp_a_q.size()), 128'd0);

    // Tag limit: five reads, only four outstanding until a response frees a slot.
    base = issued_cnt;
    applyStimulus(1'b1, mkReq(1'b0, 32'h400), 1'b0, mkReq(1'b0, 32'h0));
    applyStimulus(1'b0, mkReq(1'b0, 32'h0), 1'b1, mkReq(1'b0, 32'h404));
    applyStimulus(1'b1, mkReq(1'b0, 32'h408), 1'b0, mkReq(1'b0, 32'h0));
    applyStimulus(1'b0, mkReq(1'b0, 32'h0), 1'b1, mkReq(1'b0, 32'h40C));
    applyStimulus(1'b1, mkReq(1'b0, 32'h410), 1'b0, mkReq(1'b0, 32'h0));
    waitCycles(6);
    checkOutput("tag_issued_4", 128'(issued_cnt - base), 128'd4);
    checkOutput("tag_held_valid", 128'(mem_valid), 128'd0);
    sendResponse(128'h1111_0000_0000_0000_0000_0000_0000_AAAA);
    waitCycles(4);
    checkOutput("tag_issued_5", 128'(issued_cnt - base), 128'd5);
    sendResponse(128'h2222_0000_0000_0000_0000_0000_0000_BBBB);
    sendResponse(128'h3333_0000_0000_0000_0000_0000_0000_CCCC);
    sendResponse(128'h4444_0000_0000_0000_0000_0000_0000_DDDD);
    sendResponse(128'h5555_0000_0000_0000_0000_0000_0000_EEEE);
    waitCycles(1);
    checkOutput("tag_all_returned", 128'(tag_model_q.size()), 128'd0);
    checkOutput("tag_no_orphan", 128'(rsp_orphan_err), 128'd0);

    // Orphan response sets a sticky error that only reset clears.
    sendResponse(128'h0BAD_0000_0000_0000_0000_0000_0000_0BAD);
    checkOutput("orphan_set", 128'(rsp_orphan_err), 128'd1);
    waitCycles(5);
    checkOutput("orphan_sticky", 128'(rsp_orphan_err), 128'd1);
    doReset(2);
    checkOutput("orphan_cleared", 128'(rsp_orphan_err), 128'd0);
    checkOutput("final_mem_valid", 128'(mem_valid), 128'd0);
    checkOutput("final_exp_empty", 128'(exp_a_q.size() + exp_b_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
